// File: rtl/frog_bit_packer.sv
// Serial-to-parallel packer: assembles W enabled bits into words, buffers them in a DEPTH-word FIFO.
// Define FROG_PACKER_VN_DEBIAS_EN to insert a von Neumann debiaser ahead of the assembly register.
module frog_bit_packer #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         bit_in,
    input  logic                         clear,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [W-1:0]                 m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;
    logic [W-1:0]  r_mem [DEPTH];

    logic          w_bit_vld;
    logic          w_bit;
    logic          w_cap;
    logic          w_word_done;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [W-1:0]  w_shift_next;

`ifdef FROG_PACKER_VN_DEBIAS_EN
    // Pair phase: first bit of a pair is parked in r_first, the second edge decides the output.
    logic r_phase;
    logic r_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_first <= 1'b0;
        end else if (clear) begin
            r_phase <= 1'b0;
            r_first <= 1'b0;
        end else if (enable) begin
            r_phase <= ~r_phase;
            if (!r_phase)
                r_first <= bit_in;
        end
    end

    assign w_bit_vld = enable && r_phase && (r_first != bit_in);
    assign w_bit     = r_first;
`else
    assign w_bit_vld = enable;
    assign w_bit     = bit_in;
`endif

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shift_next = {r_shift[W-2:0], w_bit};
        end else begin : g_lsb
            assign w_shift_next = {w_bit, r_shift[W-1:1]};
        end
    endgenerate

    assign w_cap       = w_bit_vld && !clear;
    assign w_word_done = w_cap && (r_cnt == CW'(W-1));
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_pop       = m_valid && m_ready && !clear;
    // A pop on the same edge frees the slot, so a full FIFO can still accept the word.
    assign w_push      = w_word_done && (!w_full || w_pop);
    assign w_drop      = w_word_done && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_shift <= w_shift_next;
                r_cnt   <= w_word_done ? '0 : r_cnt + CW'(1);
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF)
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_shift_next;
    end

    assign m_valid  = (r_level != '0);
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_frog_bit_packer.sv
// Randomised and directed bench for frog_bit_packer; two DUTs (MSB-first and LSB-first) share stimulus.
// A queue-based model predicts every output after each edge.
module tb_frog_bit_packer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic bit_in = 1'b0;
    logic clear = 1'b0;
    logic m_ready = 1'b0;

    logic          mv1, mv0, ov1, ov0;
    logic [W-1:0]  md1, md0;
    logic [LW-1:0] lv1, lv0;
    logic [7:0]    dc1, dc0;

    frog_bit_packer #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in), .clear(clear),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .level(lv1),
        .overflow(ov1), .drop_cnt(dc1));

    frog_bit_packer #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in), .clear(clear),
        .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .level(lv0),
        .overflow(ov0), .drop_cnt(dc0));

    always #5 clk = ~clk;

    // Model state: received bits of the current word, FIFO contents per bit order, drop bookkeeping.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit           bits[$];
    bit           pair[$];
    int           drops;
    bit           ovf;
    int           tests = 0;
    int           fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        q1.delete(); q0.delete(); bits.delete(); pair.delete();
        drops = 0; ovf = 0;
    endtask

    task automatic check_all();
        chk("m_valid_msb", int'(mv1), int'(q1.size() != 0));
        chk("m_valid_lsb", int'(mv0), int'(q0.size() != 0));
        chk("m_data_msb", int'(md1), (q1.size() != 0) ? int'(q1[0]) : 0);
        chk("m_data_lsb", int'(md0), (q0.size() != 0) ? int'(q0[0]) : 0);
        chk("level_msb", int'(lv1), q1.size());
        chk("level_lsb", int'(lv0), q0.size());
        chk("overflow", int'(ov1), int'(ovf));
        chk("overflow_lsb", int'(ov0), int'(ovf));
        chk("drop_cnt", int'(dc1), drops);
        chk("drop_cnt_lsb", int'(dc0), drops);
    endtask

    // Predict the effect of the coming edge from the current inputs.
    task automatic model_step(output bit popped, output logic [W-1:0] pword);
        bit have;
        bit b;
        logic [W-1:0] w1, w0;
        popped = 0; pword = '0; have = 0; b = 0;
        if (clear) begin
            model_clear();
            return;
        end
        if (q1.size() != 0 && m_ready) begin
            popped = 1;
            pword = q1.pop_front();
            void'(q0.pop_front());
        end
        if (enable) begin
`ifdef FROG_PACKER_VN_DEBIAS_EN
            pair.push_back(bit_in);
            if (pair.size() == 2) begin
                if (pair[0] != pair[1]) begin
                    have = 1;
                    b = pair[0];
                end
                pair.delete();
            end
`else
            have = 1;
            b = bit_in;
`endif
        end
        if (have) begin
            bits.push_back(b);
            if (bits.size() == W) begin
                w1 = '0; w0 = '0;
                for (int i = 0; i < W; i++) begin
                    w1 = (w1 << 1) | W'(bits[i]);
                    w0[i] = bits[i];
                end
                if (q1.size() < DEPTH) begin
                    q1.push_back(w1);
                    q0.push_back(w0);
                end else begin
                    ovf = 1;
                    if (drops < 255) drops++;
                end
                bits.delete();
            end
        end
    endtask

    task automatic tick(input bit en, input bit b, input bit rdy, input bit clr);
        bit popped;
        logic [W-1:0] pword;
        enable = en; bit_in = b; m_ready = rdy; clear = clr;
        model_step(popped, pword);
        @(posedge clk);
        #1;
        check_all();
        if (popped)
            $display("[TB] t=%0t pop data=%02h level=%0d", $time, pword, lv1);
    endtask

    task automatic do_reset();
        enable = 0; bit_in = 0; clear = 0; m_ready = 0;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    // Under the debiaser each logical bit b is sent as the pair (b, ~b).
    task automatic send_bit(input bit b, input bit rdy);
`ifdef FROG_PACKER_VN_DEBIAS_EN
        tick(1, b, 0, 0);
        tick(1, ~b, rdy, 0);
`else
        tick(1, b, rdy, 0);
`endif
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = W-1; i >= 0; i--) send_bit(w[i], rdy);
    endtask

    logic [W-1:0] seq1;
    logic [W-1:0] wd;

    initial begin
        do_reset();
        chk("rst_m_valid", int'(mv1), 0);
        chk("rst_m_data", int'(md1), 0);
        chk("rst_level", int'(lv1), 0);
        chk("rst_drop_cnt", int'(dc1), 0);

        // Bits 1,0,1,1,0,0,0,1
        seq1 = 8'b10110001;
        for (int i = W-1; i >= 0; i--) send_bit(seq1[i], 1'b1);
        chk("first_word_valid", int'(mv1), 1);
        chk("first_word_msb", int'(md1), 8'hB1);
        chk("first_word_lsb", int'(md0), 8'h8D);
        tick(0, 0, 1, 0);
        chk("after_pop_valid", int'(mv1), 0);

        // Back-pressure: five words into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send_word(W'(k), 1'b0);
        chk("full_level", int'(lv1), 4);
        chk("full_overflow", int'(ov1), 1);
        chk("full_drop_cnt", int'(dc1), 1);
        repeat (3) tick(0, 0, 0, 0);
        chk("stall_hold", int'(md1), 8'h01);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", int'(md1), k);
            tick(0, 0, 1, 0);
        end
        chk("drained_valid", int'(mv1), 0);

        // Fifth word completes on the same edge as a pop
        tick(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), 1'b0);
        wd = 8'h15;
        for (int i = W-1; i >= 1; i--) send_bit(wd[i], 1'b0);
        send_bit(wd[0], 1'b1);
        chk("simul_overflow", int'(ov1), 0);
        chk("simul_level", int'(lv1), 4);
        chk("simul_drop", int'(dc1), 0);
        for (int k = 0; k < 4; k++) begin
            chk("simul_order", int'(md1), 8'h12 + k);
            tick(0, 0, 1, 0);
        end

        // Enable pause mid-word
        wd = 8'hC6;
        for (int i = W-1; i >= W-3; i--) send_bit(wd[i], 1'b0);
        repeat (10) begin
            tick(0, 1'($urandom), 1'b0, 0);
            chk("pause_no_push", int'(lv1), 0);
        end
        for (int i = W-4; i >= 0; i--) send_bit(wd[i], 1'b0);
        chk("pause_word", int'(md1), 8'hC6);
        chk("pause_level", int'(lv1), 1);
        tick(0, 0, 1, 0);

        // Drop counter saturation
        for (int k = 0; k < 260; k++) send_word(W'(k), 1'b0);
        chk("sat_drop_cnt", int'(dc1), 255);
        chk("sat_overflow", int'(ov1), 1);

        // Clear with level 3 and a partial word
        tick(0, 0, 1, 0);
        wd = 8'hF0;
        for (int i = W-1; i >= W-4; i--) send_bit(wd[i], 1'b0);
        chk("pre_clear_level", int'(lv1), 3);
        tick(0, 0, 0, 1);
        chk("clear_level", int'(lv1), 0);
        chk("clear_valid", int'(mv1), 0);
        chk("clear_overflow", int'(ov1), 0);
        chk("clear_drop", int'(dc1), 0);
        send_word(8'h5A, 1'b0);
        chk("fresh_word", int'(md1), 8'h5A);
        tick(0, 0, 1, 0);

`ifdef FROG_PACKER_VN_DEBIAS_EN
        tick(0, 0, 0, 1);
        repeat (4) begin
            tick(1, 1, 0, 0); tick(1, 0, 0, 0);
            tick(1, 0, 0, 0); tick(1, 1, 0, 0);
            tick(1, 0, 0, 0); tick(1, 0, 0, 0);
            tick(1, 1, 0, 0); tick(1, 1, 0, 0);
        end
        chk("debias_msb", int'(md1), 8'hAA);
        chk("debias_lsb", int'(md0), 8'h55);
        chk("debias_level", int'(lv1), 1);
`endif

        // Random traffic with occasional clear and one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frog_bit_packer.md
Name: frog_bit_packer

Overview:
- Downstream stage of frog_chip; consumes its 1-bit serial `out` stream while `enable` is high.
- Assembles W consecutive bits into a word and buffers words in a small FIFO.
- Presents words on a valid/ready interface to the consumer, e.g. a bus bridge or UART.
- Counts and flags words lost to back-pressure.

Parameters:
- W, 8, bits per output word (>=2).
- DEPTH, 4, FIFO depth in words (power of 2, >=2).
- MSB_FIRST, 1, 1: first bit received lands in m_data[W-1]; 0: lands in m_data[0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  bit-valid qualifier; same signal that enables frog_chip.
- bit_in  in  1  serial bit from frog_chip `out`.
- clear  in  1  synchronous flush.
- m_valid  out  1  FIFO head word available.
- m_ready  in  1  consumer accepts the head word.
- m_data  out  W  FIFO head word.
- level  out  $clog2(DEPTH+1)  words currently stored.
- overflow  out  1  sticky flag: at least one word was dropped.
- drop_cnt  out  8  saturating count of dropped words.

Behaviour:
- Reset (async, rst_n=0): shift register, bit counter, FIFO pointers, level, overflow and drop_cnt all clear to 0; m_valid=0; m_data=0.
- Bit capture: on each rising edge with enable=1 and clear=0, bit_in shifts into the assembly register.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - The bit counter increments 0..W-1.
- Word completion: on the edge that captures the W-th bit, the complete word (including that bit) is pushed and the bit counter wraps to 0.
  - The pushed word is visible on m_data with m_valid=1 after that same edge, if the FIFO was empty.
  - Latency: W enabled edges from the first bit to m_valid.
- Pop: a word is transferred on an edge where m_valid&&m_ready. The read pointer advances and m_data shows the next word, or 0 if the FIFO is now empty.
  - m_data must hold stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop:
  - FIFO non-full: both happen and level is unchanged.
  - FIFO full with a pop the same cycle: the push is accepted, no drop occurs and level stays DEPTH.
- Full boundary: word completes, level==DEPTH and no pop in the same cycle.
  - The word is discarded and overflow is set (sticky).
  - drop_cnt increments, saturating at 255.
  - The bit counter still wraps, so framing stays aligned.
- Empty boundary: m_valid=0 and m_ready is ignored; no underflow is possible.
- enable=0: no capture and the bit counter holds. A partial word is retained and resumes when enable returns.
- clear=1 (synchronous):
  - Resets the bit counter and assembly register, empties the FIFO, and zeroes overflow and drop_cnt.
  - Takes priority over capture, push and pop in that cycle.
  - m_valid=0 on the following cycle.
- Reset mid-word or mid-transfer: all state is lost. The first bit after reset release starts a new word.
- level always equals pushes minus pops, within 0..DEPTH.

Optional Feature:
- Macro: FROG_PACKER_VN_DEBIAS_EN.
- Defined: a von Neumann debiaser sits between bit_in and the assembly register.
  - Enabled bits are taken in pairs (first, second).
  - Pair 10 emits bit 1 and pair 01 emits bit 0, one shifted bit on the second edge of the pair.
  - Pairs 00 and 11 emit nothing.
  - The pair phase is cleared by reset and by clear, and is held while enable=0.
  - Word completion counts emitted bits only.
- Not defined: raw bits are packed directly; the debiaser logic is not present.

Test Plan:
- Reset then enable with bits 1,0,1,1,0,0,0,1, m_ready=1, MSB_FIRST=1 -> m_valid=1 after the 8th edge with m_data=8'hB1, then m_valid=0 after the pop. With MSB_FIRST=0 the same bits give 8'h8D.
- m_ready=0, stream 5 words 8'h01,8'h02,8'h03,8'h04,8'h05 (DEPTH=4) -> level=4, overflow=1, drop_cnt=1. Draining gives 01,02,03,04 in order and m_data holds stable while stalled.
- FIFO full, and the 5th word completes on the same edge as a pop -> no drop, overflow=0, level stays 4. The final pops show the word sequence intact.
- Deassert enable after 3 bits for 10 cycles, then resume with 5 more bits -> a single correct word and no spurious push during the pause.
- Assert clear with level=3 and 4 partial bits -> next cycle level=0, m_valid=0, overflow=0. The next 8 bits form a fresh word.
- With FROG_PACKER_VN_DEBIAS_EN defined, bits 10,01,00,11 repeated 4 times -> one word of alternating 1,0 bits = 8'hAA (MSB_FIRST=1) after 32 enabled edges.
